// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, queue entry type and lane popcount for the write-back queue.
//   XLEN / RA_W  : data and register-address widths
//   wb_entry_t   : one queued result {addr, data}
//   popcount_lanes: number of set bits in a lane mask (up to 4 lanes)
package wb_pkg;
    localparam int XLEN = 32;
    localparam int RA_W = 5;

    typedef struct packed {
        logic [RA_W-1:0] addr;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    function automatic logic [2:0] popcount_lanes(input logic [3:0] mask);
        return 3'(mask[0]) + 3'(mask[1]) + 3'(mask[2]) + 3'(mask[3]);
    endfunction
endpackage

// File: rtl/wb_mq_fifo.sv
// wb_mq_fifo: multi-push / multi-pop circular buffer of wb_entry_t.
//   clk, reset   : clock, synchronous active-high reset (pointers and count)
//   push_en      : write the masked lanes of push_data this edge
//   push_mask    : per-lane valid; set lanes are compacted in ascending order
//   push_data    : per-lane entries
//   pop_n        : number of head entries to retire this edge
//   head_o       : the LANES oldest entries (valid up to count_o)
//   count_o      : occupancy
//   mem_o, rd_ptr_o : raw storage and head pointer (only with WB_BYPASS_EN)
module wb_mq_fifo
    import wb_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_en,
    input  logic [LANES-1:0]        push_mask,
    input  wb_entry_t [LANES-1:0]   push_data,
    input  logic [AW-1:0]           pop_n,
    output wb_entry_t [LANES-1:0]   head_o,
    output logic [CW-1:0]           count_o
`ifdef WB_BYPASS_EN
    ,
    output wb_entry_t [DEPTH-1:0]   mem_o,
    output logic [AW-1:0]           rd_ptr_o
`endif
);
    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, off;
    logic [CW-1:0] count_q, count_d;
    logic [2:0] pushed;
    logic [3:0] mask4;

    assign mask4 = 4'(push_mask);

    // off tracks how many lanes below the current one were valid, so set
    // lanes land in consecutive slots after the tail with no holes.
    always_comb begin
        mem_d = mem_q;
        off = '0;
        pushed = push_en ? popcount_lanes(mask4) : 3'd0;
        for (int i = 0; i < LANES; i++) begin
            if (push_en && push_mask[i]) begin
                mem_d[wr_ptr_q + off] = push_data[i];
                off = off + AW'(1);
            end
        end
        wr_ptr_d = wr_ptr_q + off;
        rd_ptr_d = rd_ptr_q + pop_n;
        count_d = count_q + CW'(pushed) - CW'(pop_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every use of it.
    always_ff @(posedge clk) mem_q <= mem_d;

    for (genvar k = 0; k < LANES; k++) begin : g_head
        assign head_o[k] = mem_q[rd_ptr_q + AW'(k)];
    end

    assign count_o = count_q;
`ifdef WB_BYPASS_EN
    assign mem_o = mem_q;
    assign rd_ptr_o = rd_ptr_q;
`endif
endmodule

// File: rtl/wb_retire_queue.sv
// wb_retire_queue: buffered multi-lane write-back stage with x0 suppression.
//   clk, reset            : clock, synchronous active-high reset
//   prev_valid_i / self_ready_o : upstream bundle handshake
//   lane_valid_i, rd_addr_i, rd_data_i : bundle of up to LANES results
//   stall_i               : freezes accept and drain
//   next_ready_i          : register file accepts writes this cycle
//   self_valid_o          : registered; some entry was retired on the last edge
//   rd_en_o, rd_addr_o, rd_data_o : LANES register-file write ports
//   count_o               : queue occupancy
//   byp_rs_i, byp_hit_o, byp_data_o : operand bypass (only with WB_BYPASS_EN)
module wb_retire_queue
    import wb_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      prev_valid_i,
    output logic                      self_ready_o,
    input  logic [LANES-1:0]          lane_valid_i,
    input  logic [LANES*RA_W-1:0]     rd_addr_i,
    input  logic [LANES*XLEN-1:0]     rd_data_i,
    input  logic                      stall_i,
    input  logic                      next_ready_i,
    output logic                      self_valid_o,
    output logic [LANES-1:0]          rd_en_o,
    output logic [LANES*RA_W-1:0]     rd_addr_o,
    output logic [LANES*XLEN-1:0]     rd_data_o,
    output logic [$clog2(DEPTH):0]    count_o
`ifdef WB_BYPASS_EN
    ,
    input  logic [2*RA_W-1:0]         byp_rs_i,
    output logic [1:0]                byp_hit_o,
    output logic [2*XLEN-1:0]         byp_data_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t [LANES-1:0] push_data, head;
    logic [CW-1:0] count;
    logic [AW-1:0] pop_n;
    logic accept, drain;
    logic [LANES-1:0] en_q, en_d;
    logic [LANES-1:0][RA_W-1:0] addr_q, addr_d;
    logic [LANES-1:0][XLEN-1:0] data_q, data_d;
    logic valid_q, valid_d;

    for (genvar k = 0; k < LANES; k++) begin : g_push
        assign push_data[k] = '{addr: rd_addr_i[k*RA_W +: RA_W], data: rd_data_i[k*XLEN +: XLEN]};
    end

    // Ready looks at the pre-pop count so it never depends on next_ready_i.
    assign self_ready_o = !stall_i && (CW'(DEPTH) - count >= CW'(LANES));
    assign accept = prev_valid_i && self_ready_o;
    assign drain = !stall_i && next_ready_i && count != '0;
    assign pop_n = !drain ? '0 : (count < CW'(LANES)) ? AW'(count) : AW'(LANES);

    wb_mq_fifo #(.LANES(LANES), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_en   (accept),
        .push_mask (lane_valid_i),
        .push_data (push_data),
        .pop_n     (pop_n),
        .head_o    (head),
        .count_o   (count)
`ifdef WB_BYPASS_EN
        ,
        .mem_o     (mem),
        .rd_ptr_o  (rd_ptr)
`endif
    );

    // Popped x0 entries still load the port registers but never raise rd_en.
    always_comb begin
        en_d = '0;
        addr_d = addr_q;
        data_d = data_q;
        for (int k = 0; k < LANES; k++) begin
            if (AW'(k) < pop_n) begin
                en_d[k] = head[k].addr != '0;
                addr_d[k] = head[k].addr;
                data_d[k] = head[k].data;
            end
        end
        valid_d = pop_n != '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            en_q    <= en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign rd_en_o = en_q;
    assign rd_addr_o = addr_q;
    assign rd_data_o = data_q;
    assign self_valid_o = valid_q;
    assign count_o = count;

`ifdef WB_BYPASS_EN
    wb_entry_t [DEPTH-1:0] mem;
    logic [AW-1:0] rd_ptr;
    logic [RA_W-1:0] rs;
    wb_entry_t e;

    // Scan oldest to youngest (ports, then queue head to tail); the last hit wins.
    always_comb begin
        byp_hit_o = '0;
        byp_data_o = '0;
        rs = '0;
        e = '0;
        for (int r = 0; r < 2; r++) begin
            rs = byp_rs_i[r*RA_W +: RA_W];
            for (int k = 0; k < LANES; k++) begin
                if (rs != '0 && en_q[k] && addr_q[k] == rs) begin
                    byp_hit_o[r] = 1'b1;
                    byp_data_o[r*XLEN +: XLEN] = data_q[k];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                e = mem[rd_ptr + AW'(i)];
                if (rs != '0 && CW'(i) < count && e.addr == rs) begin
                    byp_hit_o[r] = 1'b1;
                    byp_data_o[r*XLEN +: XLEN] = e.data;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_wb_retire_queue.sv
// tb_wb_retire_queue: table-driven and sequence checks of wb_retire_queue (LANES=2, DEPTH=8).
module tb_wb_retire_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        prev_valid_i = 1'b0;
    logic        self_ready_o;
    logic [1:0]  lane_valid_i = '0;
    logic [9:0]  rd_addr_i = '0;
    logic [63:0] rd_data_i = '0;
    logic        stall_i = 1'b0;
    logic        next_ready_i = 1'b0;
    logic        self_valid_o;
    logic [1:0]  rd_en_o;
    logic [9:0]  rd_addr_o;
    logic [63:0] rd_data_o;
    logic [3:0]  count_o;

    wb_retire_queue #(.LANES(2), .DEPTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .prev_valid_i (prev_valid_i),
        .self_ready_o (self_ready_o),
        .lane_valid_i (lane_valid_i),
        .rd_addr_i    (rd_addr_i),
        .rd_data_i    (rd_data_i),
        .stall_i      (stall_i),
        .next_ready_i (next_ready_i),
        .self_valid_o (self_valid_o),
        .rd_en_o      (rd_en_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [1:0]  lv;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic        nr, st;
        logic [1:0]  en;
        int          cnt;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t sbq[$];
    int checks = 0;
    int passed = 0;
    int mcnt = 0;
    logic [4:0]  pa[2];
    logic [31:0] pd[2];
    vec_t tbl[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        prev_valid_i = 1'b0;
        lane_valid_i = '0;
        stall_i = 1'b0;
        next_ready_i = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sbq.delete();
        mcnt = 0;
        pa = '{default: '0};
        pd = '{default: '0};
        chk("rst_en", 64'(rd_en_o), 64'(0));
        chk("rst_valid", 64'(self_valid_o), 64'(0));
        chk("rst_count", 64'(count_o), 64'(0));
        chk("rst_addr", 64'(rd_addr_o), 64'(0));
        chk("rst_data", rd_data_o, 64'(0));
        chk("rst_ready", 64'(self_ready_o), 64'(1));
    endtask

    task automatic apply(input logic pv, input logic [1:0] lv, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1, input logic nr, input logic st,
                         input logic [1:0] een, input int ecnt);
        int n;
        int pushed;
        logic rdy;
        ent_t e;
        prev_valid_i = pv;
        lane_valid_i = lv;
        rd_addr_i = {a1, a0};
        rd_data_i = {d1, d0};
        next_ready_i = nr;
        stall_i = st;
        #1;
        rdy = !st && (8 - mcnt >= 2);
        chk("ready", 64'(self_ready_o), 64'(rdy));
        n = (!st && nr && mcnt > 0) ? (mcnt < 2 ? mcnt : 2) : 0;
        pushed = 0;
        if (pv && rdy) begin
            if (lv[0]) begin sbq.push_back('{a0, d0}); pushed++; end
            if (lv[1]) begin sbq.push_back('{a1, d1}); pushed++; end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (k < n) begin
                e = sbq.pop_front();
                pa[k] = e.a;
                pd[k] = e.d;
                chk("port_en", 64'(rd_en_o[k]), 64'(e.a != 0));
            end else begin
                chk("idle_en", 64'(rd_en_o[k]), 64'(0));
            end
            chk("port_addr", 64'(rd_addr_o[k*5 +: 5]), 64'(pa[k]));
            chk("port_data", 64'(rd_data_o[k*32 +: 32]), 64'(pd[k]));
        end
        mcnt = mcnt + pushed - n;
        chk("valid", 64'(self_valid_o), 64'(n > 0));
        chk("count", 64'(count_o), 64'(mcnt));
        chk("tbl_en", 64'(rd_en_o), 64'(een));
        chk("tbl_count", 64'(count_o), 64'(ecnt));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'b11, 5'd5,  5'd6,  32'h11,   32'h22, 1'b1, 1'b0, 2'b00, 2};
        tbl[1]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  1'b1, 1'b0, 2'b11, 0};
        tbl[2]  = '{1'b1, 2'b11, 5'd0,  5'd7,  32'hDEAD, 32'h7,  1'b1, 1'b0, 2'b00, 2};
        tbl[3]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  1'b1, 1'b0, 2'b10, 0};
        tbl[4]  = '{1'b1, 2'b10, 5'd1,  5'd9,  32'hBAD,  32'h9,  1'b0, 1'b0, 2'b00, 1};
        tbl[5]  = '{1'b1, 2'b11, 5'd3,  5'd4,  32'h3,    32'h4,  1'b0, 1'b0, 2'b00, 3};
        tbl[6]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  1'b1, 1'b1, 2'b00, 3};
        tbl[7]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  1'b1, 1'b0, 2'b11, 1};
        tbl[8]  = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  1'b1, 1'b0, 2'b01, 0};
        tbl[9]  = '{1'b1, 2'b11, 5'd10, 5'd11, 32'hA,    32'hB,  1'b0, 1'b0, 2'b00, 2};
        tbl[10] = '{1'b1, 2'b11, 5'd12, 5'd13, 32'hC,    32'hD,  1'b1, 1'b0, 2'b11, 2};
        tbl[11] = '{1'b1, 2'b01, 5'd14, 5'd0,  32'hE,    32'h0,  1'b1, 1'b0, 2'b11, 1};
        tbl[12] = '{1'b1, 2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  1'b1, 1'b0, 2'b01, 0};
        tbl[13] = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  1'b1, 1'b0, 2'b00, 0};
        tbl[14] = '{1'b1, 2'b11, 5'd15, 5'd16, 32'hF,    32'h10, 1'b1, 1'b1, 2'b00, 0};
        tbl[15] = '{1'b0, 2'b00, 5'd0,  5'd0,  32'h0,    32'h0,  1'b1, 1'b0, 2'b00, 0};

        do_reset();
        for (int i = 0; i < 16; i++)
            apply(tbl[i].pv, tbl[i].lv, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1,
                  tbl[i].nr, tbl[i].st, tbl[i].en, tbl[i].cnt);

        // Fill to DEPTH with the register file blocked, hold a bundle while full, then drain.
        for (int b = 0; b < 4; b++)
            apply(1'b1, 2'b11, 5'(16 + 2*b), 5'(17 + 2*b), $urandom, $urandom, 1'b0, 1'b0, 2'b00, 2*b + 2);
        apply(1'b1, 2'b11, 5'd30, 5'd31, 32'h30, 32'h31, 1'b0, 1'b0, 2'b00, 8);
        for (int b = 0; b < 4; b++)
            apply(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 2'b11, 6 - 2*b);

        // Reach count 5, stall 3 cycles, then reset mid-operation.
        apply(1'b1, 2'b11, 5'd1, 5'd2, 32'h101, 32'h102, 1'b0, 1'b0, 2'b00, 2);
        apply(1'b1, 2'b11, 5'd3, 5'd4, 32'h103, 32'h104, 1'b0, 1'b0, 2'b00, 4);
        apply(1'b1, 2'b01, 5'd5, 5'd0, 32'h105, 32'h0,   1'b0, 1'b0, 2'b00, 5);
        for (int s = 0; s < 3; s++)
            apply(1'b1, 2'b11, 5'd6, 5'd7, 32'h106, 32'h107, 1'b1, 1'b1, 2'b00, 5);
        do_reset();
        apply(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0, 2'b00, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/wb_retire_queue.md
Name: wb_retire_queue

Overview:
- Parametrised write-back stage for the 32IM pipeline.
- Accepts a bundle of up to LANES results per cycle from the MEM stage into an in-order queue of DEPTH entries.
- Drains up to LANES entries per cycle onto LANES register-file write ports.
- Replaces the single-entry, single-port WB stage. Adds buffering, multi-lane retire, x0 suppression and occupancy status.

Parameters:
- LANES, 2, number of input lanes and register-file write ports (1..4).
- DEPTH, 8, queue entries; power of two, DEPTH >= 2*LANES.
- XLEN, 32, data width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- prev_valid_i  in  1  upstream bundle valid
- self_ready_o  out  1  bundle accepted when prev_valid_i && self_ready_o
- lane_valid_i  in  LANES  per-lane valid mask within the bundle
- rd_addr_i  in  LANES*RA_W  per-lane destination register
- rd_data_i  in  LANES*XLEN  per-lane result
- stall_i  in  1  control-unit stall; freezes both accept and drain
- next_ready_i  in  1  register file can take writes this cycle
- self_valid_o  out  1  registered; high when any write port was loaded on the last edge
- rd_en_o  out  LANES  per-port write enable
- rd_addr_o  out  LANES*RA_W  per-port address
- rd_data_o  out  LANES*XLEN  per-port data
- count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (synchronous, highest priority): pointers 0, count 0.
- Reset values of outputs: rd_en_o 0, rd_addr_o 0, rd_data_o 0, self_valid_o 0, count_o 0.
- Reset mid-operation discards all queued entries. No write is issued in the cycle after reset.
- self_ready_o = !stall_i && (DEPTH - count >= LANES). It uses the pre-pop count, so it is conservative and independent of next_ready_i.
- Enqueue on accept: valid lanes are compacted in ascending lane order and written at the tail. count increases by popcount(lane_valid_i).
- An accepted bundle with lane_valid_i == 0 is legal and changes nothing.
- Drain condition: !stall_i && next_ready_i && count > 0.
- Drain action: pop n = min(count, LANES) head entries. On the same edge, register entry k into port k for k < n.
- rd_en_o[k] = 1 only if k < n and the entry address != 0. x0 writes are consumed silently.
- Ports k >= n: rd_en_o[k] = 0. rd_addr_o and rd_data_o hold their previous values.
- When the drain condition is false, all rd_en_o go 0 on the next edge.
- self_valid_o is registered high on any edge where n > 0, even if every popped entry targeted x0.
- Latency: a result accepted at edge N appears on a port after edge N+1 when the queue was empty. Ordering is strictly program (queue) order.
- Same-cycle push and pop: both take effect. count_next = count + pushed - popped.
- Full condition: self_ready_o is low; an upstream bundle holds.
- Empty condition: no writes; count_o = 0.
- Pointers wrap modulo DEPTH (power of two, so no explicit compare).
- Same rd in one drain cycle: port index order equals age. The register file must give the highest port index priority; this block does not merge duplicates.
- stall_i high: no accept, no drain, queue contents and count frozen. rd_en_o goes 0 on the next edge.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Enabled: adds ports byp_rs_i (in, 2*RA_W) and byp_hit_o (out, 2), plus byp_data_o (out, 2*XLEN).
- For each rs, combinationally search queued entries plus the entries currently on the write ports.
- On a match, return the youngest data; rs == 0 never hits.
- Disabled: the ports and search logic are absent; the decode stage must stall on pending WB hazards.

Decomposition:
- Shared package wb_pkg holds XLEN, RA_W, the wb_entry_t struct {addr, data}, and the function popcount_lanes.
- Sub-module wb_mq_fifo: multi-push/multi-pop circular buffer of wb_entry_t.
  - Inputs: push mask compaction, pop count.
  - Outputs: head window of LANES entries, count.
- The top level holds the handshake, the output registers and the optional bypass.

Test Plan (LANES=2, DEPTH=8):
- Reset then idle: after reset release -> rd_en_o=00, self_valid_o=0, count_o=0, self_ready_o=1.
- Single bundle {x5=0x11, x6=0x22}, next_ready_i=1 -> one cycle later rd_en_o=11, ports (5,0x11),(6,0x22), self_valid_o=1.
- x0 suppression: bundle {x0=0xDEAD, x7=0x7} -> rd_en_o=10, port1=(7,0x7), count returns to 0.
- Fill with next_ready_i=0: 4 full bundles -> count_o=8, self_ready_o=0. Raise next_ready_i -> 4 drain cycles of 2 writes each in order, self_ready_o=1 once count<=6.
- Odd mask: lane_valid_i=10 {x9=0x9}, then bundle 11 {x3,x4}, drain stalled then released -> write order x9,x3 then x4 alone (rd_en_o=01).
- Mid-operation: count=5, assert stall_i for 3 cycles then reset -> count frozen at 5 during the stall, then 0, with no writes after reset.
